// File: rtl/soml_stbc_encoder_if.sv
// soml_stbc_encoder_if: input word handshake and transmit sample stream of the STBC encoder
interface soml_stbc_encoder_if #(parameter int N = 32);
  logic in_valid;
  logic in_ready;
  logic [11:0] data_in;
  logic out_valid;
  logic out_ready;
  logic signed [N-1:0] out_r;
  logic signed [N-1:0] out_i;
  logic [1:0] out_ant;
  logic out_slot;
  logic out_last;
  logic busy;
  modport master (
    output in_valid, data_in, out_ready,
    input in_ready, out_valid, out_r, out_i, out_ant, out_slot, out_last, busy
  );
  modport slave (
    input in_valid, data_in, out_ready,
    output in_ready, out_valid, out_r, out_i, out_ant, out_slot, out_last, busy
  );
endinterface

// File: rtl/soml_stbc_encoder.sv
// soml_stbc_encoder: maps {q, b1} to a j^k-rotated 4x2 16-QAM STBC matrix streamed as 8 samples (slot0 ant0..3, slot1 ant0..3).
// LVL1 = round(2^22/sqrt(10)); SOML_ENC_SKID_EN adds a one-word input holding buffer for back-to-back blocks.
module soml_stbc_encoder #(
  parameter int N = 32,
  parameter int LVL1 = 1326355
) (
  input logic clk,
  input logic rst,
  soml_stbc_encoder_if.slave s
);
  typedef enum logic [1:0] {IDLE, MAP, STREAM} state_t;
  state_t state, state_n;
  logic [11:0] w, w_src;
  logic [2:0] cnt;
  logic [2*N-1:0] e [4];
  logic fire_in, fire_out, done, pend, load_w;
  logic signed [N-1:0] r1, i1, r2, i2;
  logic [1:0] pa, pb, ant;
  logic [2*N-1:0] smp;

  function automatic logic signed [N-1:0] pam(input logic [1:0] g);
    return g == 2'b00 ? N'(-3 * LVL1) : g == 2'b01 ? N'(-LVL1) : g == 2'b11 ? N'(LVL1) : N'(3 * LVL1);
  endfunction

  function automatic logic [2*N-1:0] rot(input logic signed [N-1:0] r, input logic signed [N-1:0] i, input logic [1:0] k);
    return k == 2'd0 ? {r, i} : k == 2'd1 ? {-i, r} : k == 2'd2 ? {-r, -i} : {i, -r};
  endfunction

  assign r1 = pam(w[7:6]);
  assign i1 = pam(w[5:4]);
  assign r2 = pam(w[3:2]);
  assign i2 = pam(w[1:0]);
  assign pa = w[11:10] == 2'd1 ? 2'd2 : w[11:10] == 2'd3 ? 2'd1 : 2'd0;
  assign pb = w[11:10] == 2'd0 ? 2'd1 : w[11:10] == 2'd2 ? 2'd2 : 2'd3;
  assign ant = cnt[1:0];
  // entry index is {slot, antenna-is-b}
  assign smp = state != STREAM ? '0 : ant == pa ? e[{cnt[2], 1'b0}] : ant == pb ? e[{cnt[2], 1'b1}] : '0;

  assign fire_in = s.in_valid && s.in_ready;
  assign fire_out = s.out_valid && s.out_ready;
  assign done = fire_out && cnt == 3'd7;

`ifdef SOML_ENC_SKID_EN
  logic [11:0] hold;
  logic full;
  assign s.in_ready = !full;
  assign pend = full || fire_in;
  assign load_w = (fire_in && (state == IDLE || done)) || (done && full);
  assign w_src = full ? hold : s.data_in;
  always_ff @(posedge clk)
    if (rst) full <= 1'b0;
    else if (done && full) full <= 1'b0;
    else if (fire_in && !(state == IDLE || done)) begin
      hold <= s.data_in;
      full <= 1'b1;
    end
`else
  assign s.in_ready = state == IDLE;
  assign pend = 1'b0;
  assign load_w = fire_in;
  assign w_src = s.data_in;
`endif

  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (fire_in ? MAP : IDLE) : state == MAP ? STREAM : done ? (pend ? MAP : IDLE) : STREAM;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      w <= '0;
    end else begin
      state <= state_n;
      cnt <= state == MAP ? 3'd0 : fire_out ? cnt + 3'd1 : cnt;
      if (load_w) w <= w_src;
      if (state == MAP) begin
        e[0] <= rot(r1, i1, w[9:8]);
        e[1] <= rot(r2, i2, w[9:8]);
        e[2] <= rot(-r2, i2, w[9:8]);
        e[3] <= rot(r1, -i1, w[9:8]);
      end
    end

  assign s.out_valid = state == STREAM;
  assign s.out_last = state == STREAM && cnt == 3'd7;
  assign s.busy = state != IDLE;
  assign s.out_ant = ant;
  assign s.out_slot = cnt[2];
  assign s.out_r = smp[2*N-1:N];
  assign s.out_i = smp[N-1:0];
endmodule

// File: tb/tb_soml_stbc_encoder.sv
// tb_soml_stbc_encoder: vector table, reset/backpressure/back-to-back sequences and random blocks against a complex-arithmetic model
module tb_soml_stbc_encoder;
  localparam int N = 32;
  localparam int L = 1326355;
  localparam int T = 3 * L;
`ifdef SOML_ENC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cap_r [8];
  int cap_i [8];

  typedef struct {
    logic [11:0] wd;
    int slot;
    int ant;
    int er;
    int ei;
  } vec_t;
  vec_t vt [18];

  soml_stbc_encoder_if #(.N(N)) bus ();
  soml_stbc_encoder #(.N(N), .LVL1(L)) dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [11:0] wd, input int slot, input int ant, output int er, output int ei);
    int lv [4] = '{-3, -1, 3, 1};
    int pa [4] = '{0, 2, 0, 1};
    int pb [4] = '{1, 3, 2, 3};
    int jr [4] = '{1, 0, -1, 0};
    int ji [4] = '{0, 1, 0, -1};
    int q, k, ur, ui, vr, vi, xr, xi;
    q = int'(wd[11:10]);
    k = int'(wd[9:8]);
    ur = lv[wd[7:6]];
    ui = lv[wd[5:4]];
    vr = lv[wd[3:2]];
    vi = lv[wd[1:0]];
    xr = 0;
    xi = 0;
    if (ant == pa[q]) begin
      xr = slot != 0 ? -vr : ur;
      xi = slot != 0 ? vi : ui;
    end else if (ant == pb[q]) begin
      xr = slot != 0 ? ur : vr;
      xi = slot != 0 ? -ui : vi;
    end
    er = (xr * jr[k] - xi * ji[k]) * L;
    ei = (xr * ji[k] + xi * jr[k]) * L;
  endfunction

  task automatic stream_check(input logic [11:0] wd, input int st, input int sl, input string nm);
    int er, ei;
    for (int c = 0; c < 8; c++) begin
      model(wd, c / 4, c % 4, er, ei);
      chk({nm, " valid"}, bus.out_valid, 1);
      chk({nm, " r"}, bus.out_r, er);
      chk({nm, " i"}, bus.out_i, ei);
      chk({nm, " ant"}, bus.out_ant, c % 4);
      chk({nm, " slot"}, bus.out_slot, c / 4);
      chk({nm, " last"}, bus.out_last, c == 7);
      cap_r[c] = bus.out_r;
      cap_i[c] = bus.out_i;
      if (c == st) begin
        bus.out_ready = 1'b0;
        repeat (sl) begin
          @(negedge clk);
          chk({nm, " hold valid"}, bus.out_valid, 1);
          chk({nm, " hold r"}, bus.out_r, er);
          chk({nm, " hold i"}, bus.out_i, ei);
          chk({nm, " hold ant"}, bus.out_ant, c % 4);
          chk({nm, " hold slot"}, bus.out_slot, c / 4);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_block(input logic [11:0] wd, input int st, input int sl, input string nm);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.data_in = wd;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " accept"}, t < 20, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, " map valid"}, bus.out_valid, 0);
    chk({nm, " map busy"}, bus.busy, 1);
    chk({nm, " map ready"}, bus.in_ready, SKID);
    @(negedge clk);
    stream_check(wd, st, sl, nm);
    chk({nm, " end busy"}, bus.busy, 0);
    chk({nm, " end ready"}, bus.in_ready, 1);
    chk({nm, " end valid"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [11:0] lastw;
    int g;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    vt = '{
      '{12'h000, 0, 0, -T, -T}, '{12'h000, 0, 1, -T, -T}, '{12'h000, 0, 2, 0, 0}, '{12'h000, 0, 3, 0, 0},
      '{12'h000, 1, 0, T, -T},  '{12'h000, 1, 1, -T, T},  '{12'h000, 1, 2, 0, 0}, '{12'h000, 1, 3, 0, 0},
      '{12'h1F0, 0, 0, -L, L},  '{12'h1F0, 0, 1, T, -T},
      '{12'hC00, 0, 0, 0, 0},   '{12'hC00, 0, 1, -T, -T}, '{12'hC00, 0, 2, 0, 0}, '{12'hC00, 0, 3, -T, -T},
      '{12'hC00, 1, 0, 0, 0},   '{12'hC00, 1, 1, T, -T},  '{12'hC00, 1, 2, 0, 0}, '{12'hC00, 1, 3, -T, T}
    };
    repeat (2) @(negedge clk);
    chk("rst valid", bus.out_valid, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst ready", bus.in_ready, 1);
    chk("rst r", bus.out_r, 0);
    chk("rst i", bus.out_i, 0);
    chk("rst ant", bus.out_ant, 0);
    chk("rst slot", bus.out_slot, 0);
    chk("rst last", bus.out_last, 0);
    rst = 1'b0;

    lastw = 12'hFFF;
    for (int v = 0; v < 18; v++) begin
      if (vt[v].wd != lastw) run_block(vt[v].wd, 8, 0, "vec");
      lastw = vt[v].wd;
      chk($sformatf("vec%0d r", v), cap_r[vt[v].slot * 4 + vt[v].ant], vt[v].er);
      chk($sformatf("vec%0d i", v), cap_i[vt[v].slot * 4 + vt[v].ant], vt[v].ei);
    end

    run_block(12'h2A5, 3, 3, "stall");

    bus.in_valid = 1'b1;
    bus.data_in = 12'h5A3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst pre valid", bus.out_valid, 1);
    chk("midrst pre ant", bus.out_ant, 1);
    chk("midrst pre slot", bus.out_slot, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst valid", bus.out_valid, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst ready", bus.in_ready, 1);
    chk("midrst r", bus.out_r, 0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in = 12'hABC;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rstwin busy", bus.busy, 0);
    @(negedge clk);
    chk("rstwin dropped", bus.busy, 0);
    run_block(12'h3C7, 8, 0, "after_rst");

    bus.in_valid = 1'b1;
    bus.data_in = 12'h8E1;
    @(negedge clk);
    bus.data_in = 12'h47D;
    chk("b2b map ready", bus.in_ready, SKID);
    @(negedge clk);
    bus.in_valid = !SKID;
    chk("b2b stream ready", bus.in_ready, 0);
    stream_check(12'h8E1, 8, 0, "b2b a");
    g = 1;
    while (!bus.out_valid && g < 10) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      g++;
    end
    chk("b2b gap", g, SKID ? 2 : 3);
    stream_check(12'h47D, 8, 0, "b2b b");
    chk("b2b end busy", bus.busy, 0);
    chk("b2b end valid", bus.out_valid, 0);

    for (int r = 0; r < 25; r++) begin
      run_block(12'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/soml_stbc_encoder.md
Name: soml_stbc_encoder

Overview:
- Transmit-side counterpart of the SOML decoder.
- Accepts one 12-bit word {b2[3:0], b1[7:0]}, the same packing the decoder emits on signal_out_12bit.
- Maps b1 to two 16-QAM symbols (s1, s2) and b2 to the signal-matrix index q.
- Streams the 4-antenna x 2-slot transmit matrix S_q as 8 fixed-point complex samples, in the order the decoder's Y loader consumes them.

Parameters:
- N, 32, sample word width (signed fixed point).
- Q, 22, fractional bits.
- LVL1, 1326355, round(2^Q/sqrt(10)); unit PAM level. Level 3 = 3*LVL1 = 3979065.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  data_in valid
- in_ready  out  1  encoder accepts data_in this cycle
- data_in  in  12  {b2=q[3:0], b1[7:0]}
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accepts sample
- out_r  out  N  real part of sample
- out_i  out  N  imaginary part of sample
- out_ant  out  2  antenna index of current sample
- out_slot  out  1  time slot (0/1)
- out_last  out  1  high on the 8th sample of a block
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst sampled high at clk edge):
  - state=IDLE; out_valid, out_last, busy, out_ant, out_slot = 0; out_r = out_i = 0; in_ready=1.
  - Any block in progress is discarded (also mid-stream).
- Symbol mapping, Gray 2-bit to PAM: 00->-3, 01->-1, 11->+1, 10->+3 (times LVL1).
  - I1=b1[7:6], Q1=b1[5:4], I2=b1[3:2], Q2=b1[1:0].
  - s1=I1+jQ1, s2=I2+jQ2.
- Matrix index q:
  - q[3:2] selects active antenna pair (a,b): 00->(0,1), 01->(2,3), 10->(0,2), 11->(1,3).
  - q[1:0]=k selects rotation j^k.
  - Multiply by j: (r,i)->(-i,r). Exact swap/negate only, no multipliers; no saturation needed (|values| <= 3*LVL1).
- Transmit matrix, all entries times j^k:
  - Slot 0: x[a]=s1, x[b]=s2.
  - Slot 1: x[a]=-conj(s2), x[b]=conj(s1).
  - Inactive antennas output exactly 0+0j.
- Output order: slot0 ant0..3, then slot1 ant0..3 (8 samples).
- FSM IDLE -> MAP -> STREAM -> IDLE:
  - IDLE: in_ready=1. On in_valid&&in_ready, register data_in and go to MAP.
  - MAP (1 cycle): compute and register the 4 rotated entries (s1', s2', -conj(s2)', conj(s1)'); go to STREAM with sample counter=0.
  - STREAM: out_valid=1. Counter advances only on out_valid&&out_ready. out_ant=cnt[1:0], out_slot=cnt[2], out_last=(cnt==7). A handshake at cnt==7 returns to IDLE (or to MAP if a word is buffered, see feature).
- Latency: input handshake at edge t -> first out_valid at edge t+2. Minimum block period is 10 cycles without the feature.
- Backpressure: while out_valid && !out_ready, every output holds stable.
- in_ready is 0 in MAP/STREAM unless the feature is enabled.
- rst asserted in the same cycle as in_valid: reset wins, the word is dropped.

Optional Feature:
- Macro SOML_ENC_SKID_EN.
- Defined:
  - One-entry input holding buffer; in_ready = !buffer_full in every state.
  - A word accepted during MAP/STREAM is stored. After the last-sample handshake the FSM goes directly to MAP, giving back-to-back blocks with a single idle cycle (block period 9).
  - The buffer is cleared by rst.
- Undefined: in_ready high only in IDLE, no buffer.

Test Plan:
1. data_in=12'h000 (q=0, pair (0,1), k=0), out_ready=1 -> 8 samples:
   - s0a0=(-3979065,-3979065), s0a1=(-3979065,-3979065), s0a2=s0a3=(0,0);
   - s1a0=(3979065,-3979065), s1a1=(-3979065,3979065), s1a2=s1a3=(0,0);
   - out_last only on the 8th; first out_valid 2 cycles after the accept.
2. data_in=12'h1F0 (q=1, k=1; s1=(+1,+1), s2=(-3,-3)) -> s0a0=(-1326355,1326355), s0a1=(3979065,-3979065).
3. data_in=12'hC00 (pair (1,3)) -> ant0/ant2 samples are (0,0) in both slots; ant1/ant3 carry the data.
4. out_ready low for 3 cycles when cnt==3 -> out_r/out_i/out_ant/out_slot held constant, cnt stays 3, still 8 samples total.
5. rst pulsed at cnt==5 -> next cycle out_valid=0, busy=0, in_ready=1. A new word afterward streams from cnt 0.
6. Two words with in_valid held high:
   - SOML_ENC_SKID_EN defined: second accepted during STREAM; its first sample appears 2 cycles after the first block's out_last handshake.
   - Undefined: second accepted only in IDLE.
